// File: rtl/exec_monitor.sv
// Retire-stream execution monitor: saturating per-class instruction counters,
// halt detection and a no-retire watchdog for the RISC-V cores.
module exec_monitor #(
    parameter int unsigned XLEN      = 64,
    parameter int unsigned CNT_W     = 32,
    parameter int unsigned TIMEOUT   = 4096,
    parameter logic [31:0] HALT_INSN = 32'h0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             clear,
    input  logic             instr_valid,
    input  logic [31:0]      instruction,
    input  logic [XLEN-1:0]  pc,
    input  logic             branch_taken,
    output logic             busy,
    output logic             halted,
    output logic             timed_out,
    output logic             done,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt,
    output logic [CNT_W-1:0] alu_cnt,
    output logic [CNT_W-1:0] load_cnt,
    output logic [CNT_W-1:0] store_cnt,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] illegal_cnt,
    output logic [XLEN-1:0]  last_pc,
    output logic [XLEN-1:0]  halt_pc
);

    localparam int unsigned       WDOG_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StRun, StHalted, StTimeout} state_e;

    state_e state_q, state_d;

    logic [CNT_W-1:0]  cycle_q, instr_q, alu_q, load_q, store_q, branch_q, taken_q, illegal_q;
    logic [XLEN-1:0]   last_pc_q, halt_pc_q;
    logic [WDOG_W-1:0] wdog_q;
    logic              done_q;

    logic [6:0] opcode;
    logic       retire, is_halt, counted, zero;
    logic       is_alu, is_load, is_store, is_branch, is_illegal;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    assign opcode     = instruction[6:0];
    assign is_alu     = (opcode == 7'b0110011) || (opcode == 7'b0010011);
    assign is_load    = (opcode == 7'b0000011);
    assign is_store   = (opcode == 7'b0100011);
    assign is_branch  = (opcode == 7'b1100011);
    assign is_illegal = !(is_alu || is_load || is_store || is_branch);

    assign retire  = (state_q == StRun) && instr_valid;
    assign is_halt = retire && (instruction == HALT_INSN);
    assign counted = retire && !is_halt;
    // Entering RUN or clearing wipes all statistics on the same edge.
    assign zero    = clear || ((state_d == StRun) && (state_q != StRun));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:    if (start) state_d = StRun;
                StRun: begin
                    if (is_halt) begin
                        state_d = StHalted;
                    end else if (!instr_valid && (wdog_q == WDOG_LAST)) begin
                        state_d = StTimeout;
                    end
                end
                StHalted:  if (start) state_d = StRun;
                StTimeout: if (start) state_d = StRun;
                default:   state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        busy      = (state_q == StRun);
        halted    = (state_q == StHalted);
        timed_out = (state_q == StTimeout);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle_q   <= '0;
            instr_q   <= '0;
            alu_q     <= '0;
            load_q    <= '0;
            store_q   <= '0;
            branch_q  <= '0;
            taken_q   <= '0;
            illegal_q <= '0;
            last_pc_q <= '0;
            halt_pc_q <= '0;
            wdog_q    <= '0;
        end else if (zero) begin
            cycle_q   <= '0;
            instr_q   <= '0;
            alu_q     <= '0;
            load_q    <= '0;
            store_q   <= '0;
            branch_q  <= '0;
            taken_q   <= '0;
            illegal_q <= '0;
            last_pc_q <= '0;
            halt_pc_q <= '0;
            wdog_q    <= '0;
        end else begin
            if (state_q == StRun) begin
                cycle_q <= sat_inc(cycle_q);
                wdog_q  <= retire ? '0 : wdog_q + 1'b1;
            end
            if (counted) begin
                instr_q   <= sat_inc(instr_q);
                last_pc_q <= pc;
                if (is_alu)                    alu_q     <= sat_inc(alu_q);
                if (is_load)                   load_q    <= sat_inc(load_q);
                if (is_store)                  store_q   <= sat_inc(store_q);
                if (is_branch)                 branch_q  <= sat_inc(branch_q);
                if (is_branch && branch_taken) taken_q   <= sat_inc(taken_q);
                if (is_illegal)                illegal_q <= sat_inc(illegal_q);
            end
            if (is_halt) begin
                halt_pc_q <= pc;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_q <= 1'b0;
        end else begin
            done_q <= (state_q == StRun) && ((state_d == StHalted) || (state_d == StTimeout));
        end
    end

    assign done        = done_q;
    assign cycle_cnt   = cycle_q;
    assign instr_cnt   = instr_q;
    assign alu_cnt     = alu_q;
    assign load_cnt    = load_q;
    assign store_cnt   = store_q;
    assign branch_cnt  = branch_q;
    assign taken_cnt   = taken_q;
    assign illegal_cnt = illegal_q;
    assign last_pc     = last_pc_q;
    assign halt_pc     = halt_pc_q;

endmodule

// File: tb/tb_exec_monitor.sv
// Bench for exec_monitor: dut_a (CNT_W=32) is scoreboarded on done pulses,
// dut_b (CNT_W=4) shares the stimulus and covers counter saturation.
module tb_exec_monitor;

    localparam logic [31:0] ADDI = 32'h00100093;
    localparam logic [31:0] ADD  = 32'h002081b3;
    localparam logic [31:0] SD   = 32'h0030b023;
    localparam logic [31:0] LD   = 32'h0000b203;
    localparam logic [31:0] BEQ  = 32'h00000063;
    localparam logic [31:0] JAL  = 32'h0000006f;
    localparam logic [31:0] HALT = 32'h00000000;

    logic        clk = 1'b0;
    logic        reset_n, start, clear, instr_valid, branch_taken;
    logic [31:0] instruction;
    logic [63:0] pc;

    logic        a_busy, a_halted, a_timed_out, a_done;
    logic [31:0] a_cycle, a_instr, a_alu, a_load, a_store, a_branch, a_taken, a_illegal;
    logic [63:0] a_last_pc, a_halt_pc;
    logic        b_busy, b_halted, b_timed_out, b_done;
    logic [3:0]  b_cycle, b_instr, b_alu, b_load, b_store, b_branch, b_taken, b_illegal;
    logic [63:0] b_last_pc, b_halt_pc;

    exec_monitor #(.XLEN(64), .CNT_W(32), .TIMEOUT(8), .HALT_INSN(HALT)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(start), .clear(clear),
        .instr_valid(instr_valid), .instruction(instruction), .pc(pc),
        .branch_taken(branch_taken), .busy(a_busy), .halted(a_halted),
        .timed_out(a_timed_out), .done(a_done), .cycle_cnt(a_cycle), .instr_cnt(a_instr),
        .alu_cnt(a_alu), .load_cnt(a_load), .store_cnt(a_store), .branch_cnt(a_branch),
        .taken_cnt(a_taken), .illegal_cnt(a_illegal), .last_pc(a_last_pc),
        .halt_pc(a_halt_pc)
    );

    exec_monitor #(.XLEN(64), .CNT_W(4), .TIMEOUT(8), .HALT_INSN(HALT)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start), .clear(clear),
        .instr_valid(instr_valid), .instruction(instruction), .pc(pc),
        .branch_taken(branch_taken), .busy(b_busy), .halted(b_halted),
        .timed_out(b_timed_out), .done(b_done), .cycle_cnt(b_cycle), .instr_cnt(b_instr),
        .alu_cnt(b_alu), .load_cnt(b_load), .store_cnt(b_store), .branch_cnt(b_branch),
        .taken_cnt(b_taken), .illegal_cnt(b_illegal), .last_pc(b_last_pc),
        .halt_pc(b_halt_pc)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    typedef struct {
        string       name;
        logic [63:0] halted, timed_out, instr, alu, load, store, branch, taken, illegal, cycle;
        logic [63:0] halt_pc;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    task automatic push_exp(input string name, input logic [63:0] hl, to, ins, alu, ld, st,
                            br, tk, il, cy, hpc);
        exp_t x;
        x.name = name; x.halted = hl; x.timed_out = to; x.instr = ins; x.alu = alu;
        x.load = ld; x.store = st; x.branch = br; x.taken = tk; x.illegal = il;
        x.cycle = cy; x.halt_pc = hpc;
        sb.push_back(x);
    endtask

    // Every done pulse of dut_a must match exactly one queued expectation.
    always @(negedge clk) begin
        if (a_done === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious done", {63'd0, a_done}, 64'd0);
            end else begin
                e = sb.pop_front();
                check({e.name, " halted"},    {63'd0, a_halted},    e.halted);
                check({e.name, " timed_out"}, {63'd0, a_timed_out}, e.timed_out);
                check({e.name, " instr_cnt"}, {32'd0, a_instr},     e.instr);
                check({e.name, " alu_cnt"},   {32'd0, a_alu},       e.alu);
                check({e.name, " load_cnt"},  {32'd0, a_load},      e.load);
                check({e.name, " store_cnt"}, {32'd0, a_store},     e.store);
                check({e.name, " branch_cnt"},{32'd0, a_branch},    e.branch);
                check({e.name, " taken_cnt"}, {32'd0, a_taken},     e.taken);
                check({e.name, " illegal"},   {32'd0, a_illegal},   e.illegal);
                check({e.name, " cycle_cnt"}, {32'd0, a_cycle},     e.cycle);
                check({e.name, " halt_pc"},   a_halt_pc,            e.halt_pc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic retire(input logic [31:0] ins, input logic [63:0] p, input logic tk);
        instr_valid  = 1'b1;
        instruction  = ins;
        pc           = p;
        branch_taken = tk;
        tick();
        instr_valid  = 1'b0;
        branch_taken = 1'b0;
    endtask

    logic [31:0] prog [14];

    initial begin
        prog = '{ADDI, ADDI, ADDI, ADDI, ADD, ADD, ADD, ADD, SD, SD, LD, LD, BEQ, BEQ};
        reset_n = 1'b1; start = 1'b0; clear = 1'b0; instr_valid = 1'b0;
        instruction = 32'h0; pc = 64'h0; branch_taken = 1'b0;
        #2 reset_n = 1'b0;
        #10;
        check("reset busy",      {63'd0, a_busy},      64'd0);
        check("reset halted",    {63'd0, a_halted},    64'd0);
        check("reset timed_out", {63'd0, a_timed_out}, 64'd0);
        check("reset cycle_cnt", {32'd0, a_cycle},     64'd0);
        check("reset halt_pc",   a_halt_pc,            64'd0);
        @(negedge clk) reset_n = 1'b1;
        tick();

        // Program run ending in a halt at 0x78.
        start = 1'b1; tick(); start = 1'b0;
        check("start busy",  {63'd0, a_busy},  64'd1);
        check("start cycle", {32'd0, a_cycle}, 64'd0);
        push_exp("halt", 1, 0, 14, 8, 2, 2, 2, 1, 0, 15, 64'h78);
        for (int i = 0; i < 14; i++) retire(prog[i], 64'h40 + 64'(4 * i), (i == 12));
        retire(HALT, 64'h78, 1'b0);
        check("halt last_pc", a_last_pc, 64'h74);
        repeat (3) tick();
        check("halted holds cycle", {32'd0, a_cycle},  64'd15);
        check("halted stays",       {63'd0, a_halted}, 64'd1);

        // Re-arm after halt.
        start = 1'b1; tick(); start = 1'b0;
        check("rearm busy",    {63'd0, a_busy},   64'd1);
        check("rearm instr",   {32'd0, a_instr},  64'd0);
        check("rearm alu",     {32'd0, a_alu},    64'd0);
        check("rearm cycle",   {32'd0, a_cycle},  64'd0);
        check("rearm halt_pc", a_halt_pc,         64'd0);
        check("rearm last_pc", a_last_pc,         64'd0);

        retire(JAL, 64'h100, 1'b0);
        check("jal illegal", {32'd0, a_illegal}, 64'd1);
        check("jal instr",   {32'd0, a_instr},   64'd1);
        check("jal last_pc", a_last_pc,          64'h100);

        start = 1'b1; tick(); start = 1'b0;
        check("start in run busy",  {63'd0, a_busy},  64'd1);
        check("start in run cycle", {32'd0, a_cycle}, 64'd2);

        start = 1'b1; clear = 1'b1; tick(); start = 1'b0; clear = 1'b0;
        check("start+clear busy",    {63'd0, a_busy},    64'd0);
        check("start+clear illegal", {32'd0, a_illegal}, 64'd0);
        check("start+clear cycle",   {32'd0, a_cycle},   64'd0);

        for (int i = 0; i < 3; i++) retire(ADDI, 64'h200 + 64'(4 * i), 1'b0);
        check("idle instr",   {32'd0, a_instr}, 64'd0);
        check("idle alu",     {32'd0, a_alu},   64'd0);
        check("idle last_pc", a_last_pc,        64'd0);

        // Watchdog: one retire then silence.
        start = 1'b1; tick(); start = 1'b0;
        push_exp("timeout", 0, 1, 1, 1, 0, 0, 0, 0, 0, 9, 64'd0);
        retire(ADDI, 64'h300, 1'b0);
        repeat (7) tick();
        check("pre-timeout flag", {63'd0, a_timed_out}, 64'd0);
        tick();
        check("timeout flag", {63'd0, a_timed_out}, 64'd1);
        check("timeout busy", {63'd0, a_busy},      64'd0);
        repeat (2) tick();

        // Saturation on the 4-bit instance.
        clear = 1'b1; tick(); clear = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 15; i++) retire(ADDI, 64'h400, 1'b0);
        check("sat15 alu",   {60'd0, b_alu},   64'd15);
        check("sat15 instr", {60'd0, b_instr}, 64'd15);
        for (int i = 0; i < 5; i++) retire(ADDI, 64'h400, 1'b0);
        check("sat20 alu",   {60'd0, b_alu},   64'd15);
        check("sat20 instr", {60'd0, b_instr}, 64'd15);
        check("sat20 cycle", {60'd0, b_cycle}, 64'd15);
        check("sat20 load",  {60'd0, b_load},  64'd0);
        check("wide alu",    {32'd0, a_alu},   64'd20);
        clear = 1'b1; tick(); clear = 1'b0;

        // Asynchronous reset mid-run.
        start = 1'b1; tick(); start = 1'b0;
        retire(ADDI, 64'h500, 1'b0);
        retire(ADDI, 64'h504, 1'b0);
        check("pre-reset instr", {32'd0, a_instr}, 64'd2);
        #3 reset_n = 1'b0;
        #1;
        check("async busy",    {63'd0, a_busy},  64'd0);
        check("async instr",   {32'd0, a_instr}, 64'd0);
        check("async cycle",   {32'd0, a_cycle}, 64'd0);
        check("async last_pc", a_last_pc,        64'd0);
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (2) tick();
        check("post-reset busy", {63'd0, a_busy}, 64'd0);

        check("pending done events", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
